modaddsub_vec: RTL and testbench
================================

MODADDSUB_VEC -- requirements
Module: modaddsub_vec

Interface
REQ-001 The block SHALL have parameter DATA_W, default 64, giving the operand and modulus width in bits.
REQ-002 The block SHALL have parameter LANES, default 4, giving the number of parallel lanes (1..16).
REQ-003 The block SHALL have parameter PIPE, default 2, giving the number of pipeline stages (1..4).
REQ-004 Port clk_i, input, 1 bit: the single clock; one clock, all logic on its rising edge.
REQ-005 Port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-006 Port valid_i/ready_o, input/output, 1 bit each: input handshake; a transfer occurs when both are 1 on a rising edge.
REQ-007 Port opcode_i, input, 3 bits: operation select per REQ-012.
REQ-008 Port opa_i/opb_i, input, LANES*DATA_W bits each: vector operands; lane k occupies bits [k*DATA_W +: DATA_W].
REQ-009 Port ops_i/mod_i, input, DATA_W bits each: scalar operand and modulus q, shared by all lanes.
REQ-010 Port lane_mask_i, input, LANES bits: per-lane enable.
REQ-011 Output ports:
- valid_o/ready_i, output/input, 1 bit each: output handshake.
- res0_o/res1_o, output, LANES*DATA_W bits each: results.
- mask_o, output, LANES bits: lane_mask carried with the item.
- count_o, output, $clog2(PIPE+1) bits: number of items currently held.

Function
REQ-012 Opcodes SHALL be: 000 ADD_VV a+b; 001 ADD_VS a+s; 010 SUB_VV a-b; 011 SUB_VS a-s; 100 SUB_SV s-a; 101 HALF a/2 mod q; 110 BFLY res0=a+b, res1=a-b; 111 NEG q-a (0 when a=0); all results mod q.
REQ-013 Each operand SHALL be pre-reduced once (x>=q ? x-q : x) before the operation; sums SHALL be formed in DATA_W+1 bits with a single conditional subtraction of q.
REQ-014 Subtraction SHALL be x>=y ? x-y : q+x-y, with the intermediate held in DATA_W+1 bits.
REQ-015 HALF SHALL give a>>1 for even a and (a+q)>>1 for odd a, using a DATA_W+1-bit sum; results are defined only for odd q.
REQ-016 res1 SHALL be 0 for every opcode except BFLY.
REQ-017 A lane with lane_mask bit 0 SHALL output 0 on both res0 and res1 for that item; mask_o SHALL equal the captured lane_mask_i.
REQ-018 The pipeline SHALL be elastic: stage i advances when stage i+1 is empty or advancing; the last stage advances when ready_i=1.
REQ-019 ready_o SHALL equal NOT(stage 0 full) OR (stage 0 advancing).
REQ-020 Latency SHALL be exactly PIPE cycles from the accepting edge to valid_o=1 when ready_i stays 1; throughput SHALL be 1 item per cycle.
REQ-021 While valid_o=1 and ready_i=0, res0_o/res1_o/mask_o SHALL hold stable; no item SHALL be dropped or duplicated.
REQ-022 count_o SHALL increment on accept, decrement on output transfer, and stay unchanged when both occur in the same cycle.
REQ-023 With all PIPE stages full and ready_i=0, ready_o SHALL be 0.
REQ-024 Each item SHALL carry its own opcode and mod to the stage that consumes them, so back-to-back items with different opcode or q are independent.

Reset
REQ-025 While rst_n=0 at a rising edge, all stage valid bits, valid_o, count_o, res0_o, res1_o and mask_o SHALL become 0, and ready_o SHALL be 1 from the first cycle after reset.
REQ-026 Reset mid-operation SHALL discard all in-flight items without emitting any of them.

Structure
REQ-027 Opcode enum and the lane-slice helper constant SHALL live in the shared vector-unit package.
REQ-028 The per-lane combinational datapath SHALL be one sub-module, modaddsub_lane, instantiated LANES times; handshake and valid/count logic SHALL be in the top module only.

Verification
REQ-029 q=17, ADD_VV a=10, b=12, mask all 1 -> res0=5, res1=0, valid_o exactly PIPE cycles after accept.
REQ-030 q=17, BFLY a=3, b=5 -> res0=8, res1=15; SUB_SV s=3, a=5 -> res0=15; NEG a=0 -> 0.
REQ-031 q=17, HALF a=7 -> 12; HALF a=20 (pre-reduced to 3) -> 10; lane_mask=0101 -> lanes 1 and 3 output 0.
REQ-032 PIPE=2, stream 6 items, hold ready_i=0 for 3 cycles mid-stream -> ready_o=0 once 2 items are held, count_o=2, outputs stable, all 6 items emerge in order.
REQ-033 Assert rst_n=0 for 1 cycle with 2 items in flight -> no valid_o afterwards, count_o=0, ready_o=1 next cycle.
REQ-034 Back-to-back items with q=17 then q=97 and differing opcodes -> each result is computed with its own q and opcode.

Source files
------------

// File: rtl/modaddsub_vec_pkg.sv
// Shared definitions for the modular add/sub vector unit: opcode encoding and
// the helper used to locate a lane inside a packed operand vector.
package modaddsub_vec_pkg;

  localparam int unsigned OPCODE_W  = 3;
  localparam int unsigned MAX_LANES = 16;

  typedef enum logic [OPCODE_W-1:0] {
    OP_ADD_VV = 3'b000,
    OP_ADD_VS = 3'b001,
    OP_SUB_VV = 3'b010,
    OP_SUB_VS = 3'b011,
    OP_SUB_SV = 3'b100,
    OP_HALF   = 3'b101,
    OP_BFLY   = 3'b110,
    OP_NEG    = 3'b111
  } op_e;

  // Lowest bit of lane k in a packed vector of w-bit lanes.
  function automatic int unsigned lane_lsb(input int unsigned k, input int unsigned w);
    return k * w;
  endfunction

endpackage

// File: rtl/modaddsub_lane.sv
// One lane of modular arithmetic: operands are pre-reduced once against q,
// then the selected operation is applied with a single correction step.
module modaddsub_lane
  import modaddsub_vec_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  op_e               op_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic [DATA_W-1:0] s_i,
  input  logic [DATA_W-1:0] q_i,
  input  logic              en_i,
  output logic [DATA_W-1:0] res0_o,
  output logic [DATA_W-1:0] res1_o
);

  function automatic logic [DATA_W-1:0] pre_reduce(input logic [DATA_W-1:0] x,
                                                   input logic [DATA_W-1:0] q);
    return (x >= q) ? x - q : x;
  endfunction

  function automatic logic [DATA_W-1:0] mod_add(input logic [DATA_W-1:0] x,
                                                input logic [DATA_W-1:0] y,
                                                input logic [DATA_W-1:0] q);
    logic [DATA_W:0] sum;
    sum = {1'b0, x} + {1'b0, y};
    if (sum >= {1'b0, q}) sum = sum - {1'b0, q};
    return DATA_W'(sum);
  endfunction

  function automatic logic [DATA_W-1:0] mod_sub(input logic [DATA_W-1:0] x,
                                                input logic [DATA_W-1:0] y,
                                                input logic [DATA_W-1:0] q);
    logic [DATA_W:0] diff;
    if (x >= y) diff = {1'b0, x} - {1'b0, y};
    else        diff = {1'b0, q} + {1'b0, x} - {1'b0, y};
    return DATA_W'(diff);
  endfunction

  // Odd a becomes even by adding q (q odd), so the shift is an exact halving mod q.
  function automatic logic [DATA_W-1:0] mod_half(input logic [DATA_W-1:0] x,
                                                 input logic [DATA_W-1:0] q);
    logic [DATA_W:0] sum;
    sum = x[0] ? ({1'b0, x} + {1'b0, q}) : {1'b0, x};
    return DATA_W'(sum >> 1);
  endfunction

  logic [DATA_W-1:0] a_r, b_r, s_r;

  assign a_r = pre_reduce(a_i, q_i);
  assign b_r = pre_reduce(b_i, q_i);
  assign s_r = pre_reduce(s_i, q_i);

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves it
    // unassigned; that is what keeps this block free of inferred latches.
    res0_o = '0;
    res1_o = '0;
    unique case (op_i)
      OP_ADD_VV: res0_o = mod_add(a_r, b_r, q_i);
      OP_ADD_VS: res0_o = mod_add(a_r, s_r, q_i);
      OP_SUB_VV: res0_o = mod_sub(a_r, b_r, q_i);
      OP_SUB_VS: res0_o = mod_sub(a_r, s_r, q_i);
      OP_SUB_SV: res0_o = mod_sub(s_r, a_r, q_i);
      OP_HALF:   res0_o = mod_half(a_r, q_i);
      OP_BFLY: begin
        res0_o = mod_add(a_r, b_r, q_i);
        res1_o = mod_sub(a_r, b_r, q_i);
      end
      OP_NEG:    res0_o = (a_r == '0) ? '0 : q_i - a_r;
    endcase
    if (!en_i) begin
      res0_o = '0;
      res1_o = '0;
    end
  end

endmodule

// File: rtl/modaddsub_vec.sv
// Vector modular add/sub unit: LANES parallel lanes computed on accept, then
// carried through a PIPE-deep elastic register pipeline with valid/ready flow.
module modaddsub_vec
  import modaddsub_vec_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int LANES  = 4,
  parameter int PIPE   = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_n,
  input  logic                       valid_i,
  output logic                       ready_o,
  input  logic [OPCODE_W-1:0]        opcode_i,
  input  logic [LANES*DATA_W-1:0]    opa_i,
  input  logic [LANES*DATA_W-1:0]    opb_i,
  input  logic [DATA_W-1:0]          ops_i,
  input  logic [DATA_W-1:0]          mod_i,
  input  logic [LANES-1:0]           lane_mask_i,
  output logic                       valid_o,
  input  logic                       ready_i,
  output logic [LANES*DATA_W-1:0]    res0_o,
  output logic [LANES*DATA_W-1:0]    res1_o,
  output logic [LANES-1:0]           mask_o,
  output logic [$clog2(PIPE+1)-1:0]  count_o
);

  localparam int VEC_W = LANES * DATA_W;
  localparam int CNT_W = $clog2(PIPE + 1);

  logic [VEC_W-1:0] lane_r0, lane_r1;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    modaddsub_lane #(.DATA_W(DATA_W)) u_lane (
      .op_i  (op_e'(opcode_i)),
      .a_i   (opa_i[lane_lsb(k, DATA_W) +: DATA_W]),
      .b_i   (opb_i[lane_lsb(k, DATA_W) +: DATA_W]),
      .s_i   (ops_i),
      .q_i   (mod_i),
      .en_i  (lane_mask_i[k]),
      .res0_o(lane_r0[lane_lsb(k, DATA_W) +: DATA_W]),
      .res1_o(lane_r1[lane_lsb(k, DATA_W) +: DATA_W])
    );
  end

  logic [PIPE-1:0]  vld_q, vld_d, load;
  logic [VEC_W-1:0] res0_q [PIPE];
  logic [VEC_W-1:0] res1_q [PIPE];
  logic [LANES-1:0] mask_q [PIPE];
  logic [CNT_W-1:0] count_q, count_d;

  // Readiness ripples from the output back to stage 0: a stage has room when
  // it is empty or its contents move on this cycle.
  always_comb begin
    logic [PIPE:0]   room;
    logic [PIPE-1:0] adv;
    logic            accept;
    logic            out_xfer;
    room       = '0;
    adv        = '0;
    room[PIPE] = ready_i;
    for (int i = PIPE - 1; i >= 0; i--) begin
      adv[i]  = vld_q[i] & room[i+1];
      room[i] = ~vld_q[i] | adv[i];
    end
    ready_o  = room[0];
    accept   = valid_i & room[0];
    out_xfer = adv[PIPE-1];
    load     = '0;
    load[0]  = accept;
    for (int i = 1; i < PIPE; i++) load[i] = adv[i-1];
    vld_d = (vld_q & ~adv) | load;
    unique case ({accept, out_xfer})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: state updates use non-blocking assignments so every stage samples
  // its predecessor's pre-edge value regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      vld_q   <= '0;
      count_q <= '0;
      // NOTE: result registers are reset too, since the outputs must read 0
      // after reset rather than whatever the last item left behind.
      for (int i = 0; i < PIPE; i++) begin
        res0_q[i] <= '0;
        res1_q[i] <= '0;
        mask_q[i] <= '0;
      end
    end else begin
      vld_q   <= vld_d;
      count_q <= count_d;
      if (load[0]) begin
        res0_q[0] <= lane_r0;
        res1_q[0] <= lane_r1;
        mask_q[0] <= lane_mask_i;
      end
      for (int i = 1; i < PIPE; i++) begin
        if (load[i]) begin
          res0_q[i] <= res0_q[i-1];
          res1_q[i] <= res1_q[i-1];
          mask_q[i] <= mask_q[i-1];
        end
      end
    end
  end

  assign valid_o = vld_q[PIPE-1];
  assign res0_o  = res0_q[PIPE-1];
  assign res1_o  = res1_q[PIPE-1];
  assign mask_o  = mask_q[PIPE-1];
  assign count_o = count_q;

endmodule

// File: tb/tb_modaddsub_vec.sv
// Self-checking bench for modaddsub_vec: directed cases plus a random stream
// scored against a wide-arithmetic modular reference model.
module tb_modaddsub_vec;

  localparam int DW = 64;
  localparam int LN = 4;
  localparam int PP = 2;
  localparam int VW = DW * LN;

  typedef struct {
    logic [2:0]    op;
    logic [VW-1:0] a;
    logic [VW-1:0] b;
    logic [DW-1:0] s;
    logic [DW-1:0] q;
    logic [LN-1:0] m;
  } item_t;

  typedef struct {
    logic [VW-1:0] r0;
    logic [VW-1:0] r1;
    logic [LN-1:0] m;
  } exp_t;

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic                      valid_i, ready_o;
  logic [2:0]                opcode_i;
  logic [VW-1:0]             opa_i, opb_i;
  logic [DW-1:0]             ops_i, mod_i;
  logic [LN-1:0]             lane_mask_i;
  logic                      valid_o, ready_i;
  logic [VW-1:0]             res0_o, res1_o;
  logic [LN-1:0]             mask_o;
  logic [$clog2(PP+1)-1:0]   count_o;

  int    checks   = 0;
  int    failures = 0;
  exp_t  sb[$];
  item_t cur;

  modaddsub_vec #(.DATA_W(DW), .LANES(LN), .PIPE(PP)) dut (
    .clk_i      (clk),
    .rst_n      (rst_n),
    .valid_i    (valid_i),
    .ready_o    (ready_o),
    .opcode_i   (opcode_i),
    .opa_i      (opa_i),
    .opb_i      (opb_i),
    .ops_i      (ops_i),
    .mod_i      (mod_i),
    .lane_mask_i(lane_mask_i),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .res0_o     (res0_o),
    .res1_o     (res1_o),
    .mask_o     (mask_o),
    .count_o    (count_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: residues mod q computed with wide integer arithmetic;
  // halving is multiplication by the inverse of 2, i.e. (q+1)/2 for odd q.
  function automatic void ref_lane(input logic [2:0] op, input logic [DW-1:0] a, b, s, q,
                                   output logic [DW-1:0] r0, output logic [DW-1:0] r1);
    logic [191:0] ar, br, sr, qq, t0, t1;
    qq = q; ar = a; br = b; sr = s;
    if (ar >= qq) ar = ar - qq;
    if (br >= qq) br = br - qq;
    if (sr >= qq) sr = sr - qq;
    t1 = 0;
    case (op)
      3'd0: t0 = (ar + br) % qq;
      3'd1: t0 = (ar + sr) % qq;
      3'd2: t0 = (ar + qq - br) % qq;
      3'd3: t0 = (ar + qq - sr) % qq;
      3'd4: t0 = (sr + qq - ar) % qq;
      3'd5: t0 = (ar * ((qq + 1) / 2)) % qq;
      3'd6: begin t0 = (ar + br) % qq; t1 = (ar + qq - br) % qq; end
      default: t0 = (qq - ar) % qq;
    endcase
    r0 = t0[DW-1:0];
    r1 = t1[DW-1:0];
  endfunction

  function automatic exp_t model(input item_t it);
    exp_t e;
    e.r0 = '0; e.r1 = '0; e.m = it.m;
    for (int k = 0; k < LN; k++) begin
      logic [DW-1:0] x0, x1;
      ref_lane(it.op, it.a[k*DW +: DW], it.b[k*DW +: DW], it.s, it.q, x0, x1);
      if (it.m[k]) begin
        e.r0[k*DW +: DW] = x0;
        e.r1[k*DW +: DW] = x1;
      end
    end
    return e;
  endfunction

  function automatic item_t mk(input logic [2:0] op, input logic [DW-1:0] a, b, s, q,
                               input logic [LN-1:0] m);
    item_t it;
    it.op = op; it.a = {LN{a}}; it.b = {LN{b}}; it.s = s; it.q = q; it.m = m;
    return it;
  endfunction

  // Operand below 2q, so a single pre-reduction yields a proper residue.
  function automatic logic [DW-1:0] rand_opnd(input logic [DW-1:0] q);
    logic [DW-1:0] v;
    v = {$urandom, $urandom};
    while ({1'b0, v} >= {q, 1'b0}) v = v >> 1;
    return v;
  endfunction

  function automatic item_t rand_item();
    item_t it;
    it.op = 3'($urandom_range(0, 7));
    case ($urandom_range(0, 3))
      0:       it.q = 64'd17;
      1:       it.q = 64'd97;
      default: it.q = {$urandom, $urandom} | 64'd1;
    endcase
    for (int k = 0; k < LN; k++) begin
      it.a[k*DW +: DW] = rand_opnd(it.q);
      it.b[k*DW +: DW] = rand_opnd(it.q);
    end
    it.s = rand_opnd(it.q);
    it.m = 4'($urandom_range(0, 15));
    return it;
  endfunction

  task automatic set_item(input item_t it);
    cur         = it;
    opcode_i    = it.op;
    opa_i       = it.a;
    opb_i       = it.b;
    ops_i       = it.s;
    mod_i       = it.q;
    lane_mask_i = it.m;
  endtask

  // One clock: sample at the falling edge, score transfers, step past the rising edge.
  task automatic tick(output bit acc);
    exp_t e;
    @(negedge clk);
    check("count", count_o, sb.size());
    check("ready", ready_o, !(sb.size() == PP && !ready_i));
    acc = valid_i && ready_o;
    if (valid_o && ready_i) begin
      if (sb.size() == 0) check("spurious_valid", valid_o, 0);
      else begin
        e = sb.pop_front();
        check("res0", res0_o, e.r0);
        check("res1", res1_o, e.r1);
        check("mask", mask_o, e.m);
      end
    end
    if (acc) sb.push_back(model(cur));
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag);
    bit acc;
    int n;
    valid_i = 1'b0;
    ready_i = 1'b1;
    n = 0;
    while (sb.size() > 0 && n < 20) begin
      tick(acc);
      n++;
    end
    check({tag, "_drained"}, sb.size(), 0);
  endtask

  task automatic run_one(input string tag, input item_t it,
                         input logic [VW-1:0] exp_r0, input logic [VW-1:0] exp_r1);
    bit acc;
    int lat;
    ready_i = 1'b1;
    set_item(it);
    valid_i = 1'b1;
    tick(acc);
    valid_i = 1'b0;
    check({tag, "_accept"}, acc, 1);
    lat = 1;
    while (!valid_o && lat < 10) begin
      tick(acc);
      lat++;
    end
    check({tag, "_latency"}, lat, PP);
    check({tag, "_r0"}, res0_o, exp_r0);
    check({tag, "_r1"}, res1_o, exp_r1);
    tick(acc);
  endtask

  initial begin
    bit            acc;
    int            sent;
    logic [VW-1:0] held_r0, held_r1;
    logic [LN-1:0] held_m;
    item_t         stream [6];
    item_t         pending;
    bit            have_pending;

    rst_n = 1'b0;
    valid_i = 1'b0;
    ready_i = 1'b1;
    set_item(mk(3'd0, 0, 0, 0, 64'd17, '0));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("rst_valid", valid_o, 0);
    check("rst_count", count_o, 0);
    check("rst_ready", ready_o, 1);
    check("rst_res0", res0_o, 0);
    check("rst_res1", res1_o, 0);
    check("rst_mask", mask_o, 0);

    run_one("add_vv", mk(3'd0, 64'd10, 64'd12, 0, 64'd17, 4'hF), {LN{64'd5}}, '0);
    run_one("bfly", mk(3'd6, 64'd3, 64'd5, 0, 64'd17, 4'hF), {LN{64'd8}}, {LN{64'd15}});
    run_one("sub_sv", mk(3'd4, 64'd5, 0, 64'd3, 64'd17, 4'hF), {LN{64'd15}}, '0);
    run_one("neg0", mk(3'd7, 64'd0, 0, 0, 64'd17, 4'hF), '0, '0);
    run_one("half7", mk(3'd5, 64'd7, 0, 0, 64'd17, 4'hF), {LN{64'd12}}, '0);
    run_one("half20", mk(3'd5, 64'd20, 0, 0, 64'd17, 4'hF), {LN{64'd10}}, '0);
    run_one("mask0101", mk(3'd5, 64'd7, 0, 0, 64'd17, 4'b0101),
            {64'd0, 64'd12, 64'd0, 64'd12}, '0);

    // Back-to-back items with different modulus and opcode.
    ready_i = 1'b1;
    set_item(mk(3'd0, 64'd10, 64'd12, 0, 64'd17, 4'hF));
    valid_i = 1'b1;
    tick(acc);
    set_item(mk(3'd2, 64'd10, 64'd12, 0, 64'd97, 4'hF));
    tick(acc);
    valid_i = 1'b0;
    drain("b2b");

    // Six-item stream with a three-cycle output stall once two items are held.
    for (int i = 0; i < 6; i++) stream[i] = rand_item();
    sent = 0;
    held_r0 = '0; held_r1 = '0; held_m = '0;
    for (int t = 0; t < 40 && (sent < 6 || sb.size() > 0); t++) begin
      ready_i = (t >= 2 && t < 5) ? 1'b0 : 1'b1;
      valid_i = (sent < 6);
      if (sent < 6) set_item(stream[sent]);
      #1;
      if (t >= 2 && t < 5) begin
        check("stall_ready", ready_o, 0);
        check("stall_count", count_o, 2);
        check("stall_valid", valid_o, 1);
        if (t == 2) begin
          held_r0 = res0_o; held_r1 = res1_o; held_m = mask_o;
        end else begin
          check("stall_hold_r0", res0_o, held_r0);
          check("stall_hold_r1", res1_o, held_r1);
          check("stall_hold_m", mask_o, held_m);
        end
      end
      tick(acc);
      if (acc) sent++;
    end
    check("stream_sent", sent, 6);
    drain("stream");

    // Reset with two items in flight.
    ready_i = 1'b0;
    set_item(rand_item());
    valid_i = 1'b1;
    tick(acc);
    set_item(rand_item());
    tick(acc);
    valid_i = 1'b0;
    check("flight_count", count_o, 2);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    sb.delete();
    check("midrst_valid", valid_o, 0);
    check("midrst_count", count_o, 0);
    check("midrst_ready", ready_o, 1);
    ready_i = 1'b1;
    repeat (4) begin
      tick(acc);
      check("midrst_no_emit", valid_o, 0);
    end

    // Random traffic with random back-pressure.
    have_pending = 1'b0;
    pending = rand_item();
    for (int t = 0; t < 300; t++) begin
      if (!have_pending && $urandom_range(0, 3) != 0) begin
        pending = rand_item();
        have_pending = 1'b1;
      end
      valid_i = have_pending;
      set_item(pending);
      ready_i = ($urandom_range(0, 3) != 0);
      tick(acc);
      if (acc) have_pending = 1'b0;
    end
    drain("random");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
